// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl -- CPU clock source for the 8-bit computer.
//
// Selects between the free-running slowClk and the single-step pressClk toggle,
// applies halt, and produces a fastClk-domain clock level plus a one-cycle
// rising-edge strobe. The CPU registers use cpuTick_o as their clock enable.
//
// Ports
//   fastClk_i       system clock; all logic is on its rising edge
//   reset_i         asynchronous, active-high; clears all state
//   slowClk_i       free-running square wave (async)
//   pressClk_i      toggles once per debounced button press (async)
//   clockChooser_i  0 = run from slowClk, 1 = single-step from pressClk (async)
//   halt_i          HLT decode from the CPU, fastClk-synchronous level
//   clearHalt_i     operator resume request (async level)
//   cpuClk_o        registered CPU clock level (drives the clock LED)
//   cpuTick_o       high for one cycle, the cycle cpuClk_o goes 0->1
//   halted_o        sticky halt status
//   tickCount_o     cpuTick_o pulses since reset, wrapping

// One async input: SYNC_STAGES-deep synchronizer plus a history flop. The
// history always follows the synced level, so an edge is only ever reported
// for the single cycle in which it arrives; nothing stale survives a GUARD.
module cpu_clock_ctrl_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic hist_o
);
    logic [STAGES-1:0] chain_q;
    logic              hist_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain_q <= '0;
            hist_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], async_i};
            hist_q  <= chain_q[STAGES-1];
        end
    end

    assign sync_o = chain_q[STAGES-1];
    assign hist_o = hist_q;
endmodule

module cpu_clock_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int PULSE_LEN    = 4,
    parameter int GUARD_CYCLES = 16,
    parameter int CNT_W        = 16
) (
    input  logic             fastClk_i,
    input  logic             reset_i,
    input  logic             slowClk_i,
    input  logic             pressClk_i,
    input  logic             clockChooser_i,
    input  logic             halt_i,
    input  logic             clearHalt_i,
    output logic             cpuClk_o,
    output logic             cpuTick_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] tickCount_o
);
    localparam int NSYNC = 4;
    localparam int GW    = $clog2(GUARD_CYCLES + 1);
    localparam int PW    = $clog2(PULSE_LEN + 1);

    typedef enum logic [1:0] {ST_GUARD, ST_RUN, ST_STEP, ST_HALTED} state_e;

    typedef struct packed {
        logic slow_rise;
        logic slow_fall;
        logic press_tog;
        logic mode_edge;
        logic mode_lvl;
        logic clr_rise;
    } evt_t;

    // ---------------- synchronizers ----------------
    // bit 0 slowClk, 1 pressClk, 2 clockChooser, 3 clearHalt
    logic [NSYNC-1:0] async_in, lvl, hist;
    assign async_in = {clearHalt_i, clockChooser_i, pressClk_i, slowClk_i};

    for (genvar g = 0; g < NSYNC; g++) begin : g_sync
        cpu_clock_ctrl_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk_i  (fastClk_i),
            .rst_i  (reset_i),
            .async_i(async_in[g]),
            .sync_o (lvl[g]),
            .hist_o (hist[g])
        );
    end

    evt_t ev;
    always_comb begin
        ev.slow_rise = lvl[0] & ~hist[0];
        ev.slow_fall = ~lvl[0] & hist[0];
        ev.press_tog = lvl[1] ^ hist[1];
        ev.mode_edge = lvl[2] ^ hist[2];
        ev.mode_lvl  = lvl[2];
        ev.clr_rise  = lvl[3] & ~hist[3];
    end

    // ---------------- control FSM ----------------
    state_e           state_q, state_d;
    logic [GW-1:0]    guard_q, guard_d;
    logic [PW-1:0]    pulse_q, pulse_d;
    logic             cpuClk_q, cpuClk_d;
    logic             cpuTick_q, cpuTick_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] tickCount_q, tickCount_d;

    always_ff @(posedge fastClk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_GUARD;
            guard_q     <= GW'(GUARD_CYCLES);
            pulse_q     <= '0;
            cpuClk_q    <= 1'b0;
            cpuTick_q   <= 1'b0;
            halted_q    <= 1'b0;
            tickCount_q <= '0;
        end else begin
            state_q     <= state_d;
            guard_q     <= guard_d;
            pulse_q     <= pulse_d;
            cpuClk_q    <= cpuClk_d;
            cpuTick_q   <= cpuTick_d;
            halted_q    <= halted_d;
            tickCount_q <= tickCount_d;
        end
    end

    // Priority: halt > mode change > clock edge. Suppressed edges are simply
    // dropped; the history flops have already moved past them.
    always_comb begin
        state_d   = state_q;
        guard_d   = guard_q;
        pulse_d   = pulse_q;
        cpuClk_d  = cpuClk_q;
        cpuTick_d = 1'b0;
        halted_d  = halted_q;

        if (halt_i && state_q != ST_HALTED) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
            cpuClk_d = 1'b0;
            pulse_d  = '0;
        end else begin
            unique case (state_q)
                ST_GUARD: begin
                    cpuClk_d = 1'b0;
                    if (guard_q <= GW'(1))
                        state_d = ev.mode_lvl ? ST_STEP : ST_RUN;
                    else
                        guard_d = guard_q - GW'(1);
                end
                ST_RUN: begin
                    if (ev.mode_edge) begin
                        state_d  = ST_GUARD;
                        guard_d  = GW'(GUARD_CYCLES);
                        cpuClk_d = 1'b0;
                    end else if (ev.slow_rise) begin
                        cpuClk_d  = 1'b1;
                        cpuTick_d = 1'b1;
                    end else if (ev.slow_fall) begin
                        cpuClk_d = 1'b0;
                    end
                end
                ST_STEP: begin
                    if (ev.mode_edge) begin
                        state_d  = ST_GUARD;
                        guard_d  = GW'(GUARD_CYCLES);
                        cpuClk_d = 1'b0;
                        pulse_d  = '0;
                    end else if (pulse_q != '0) begin
                        // pulse in progress: toggles are dropped, not queued
                        pulse_d = pulse_q - PW'(1);
                        if (pulse_q == PW'(1))
                            cpuClk_d = 1'b0;
                    end else if (ev.press_tog) begin
                        cpuClk_d  = 1'b1;
                        cpuTick_d = 1'b1;
                        pulse_d   = PW'(PULSE_LEN);
                    end
                end
                ST_HALTED: begin
                    cpuClk_d = 1'b0;
                    if (ev.clr_rise && !halt_i) begin
                        halted_d = 1'b0;
                        state_d  = ST_GUARD;
                        guard_d  = GW'(GUARD_CYCLES);
                    end
                end
                default: state_d = ST_GUARD;
            endcase
        end

        tickCount_d = tickCount_q + {{(CNT_W-1){1'b0}}, cpuTick_d};
    end

    assign cpuClk_o    = cpuClk_q;
    assign cpuTick_o   = cpuTick_q;
    assign halted_o    = halted_q;
    assign tickCount_o = tickCount_q;
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: directed scenarios plus a randomized soak, every
// cycle compared against an event-level reference model.
module tb_cpu_clock_ctrl;
    localparam int S  = 2;
    localparam int PL = 4;
    localparam int GC = 16;
    localparam int CW = 4;

    logic          fastClk = 1'b0;
    logic          reset, slowClk, pressClk, clockChooser, halt, clearHalt;
    logic          cpuClk_o, cpuTick_o, halted_o;
    logic [CW-1:0] tickCount_o;

    cpu_clock_ctrl #(.SYNC_STAGES(S), .PULSE_LEN(PL), .GUARD_CYCLES(GC), .CNT_W(CW)) dut (
        .fastClk_i     (fastClk),
        .reset_i       (reset),
        .slowClk_i     (slowClk),
        .pressClk_i    (pressClk),
        .clockChooser_i(clockChooser),
        .halt_i        (halt),
        .clearHalt_i   (clearHalt),
        .cpuClk_o      (cpuClk_o),
        .cpuTick_o     (cpuTick_o),
        .halted_o      (halted_o),
        .tickCount_o   (tickCount_o)
    );

    always #5 fastClk = ~fastClk;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    // ---------------- reference model ----------------
    // Input histories: bit i holds the input value sampled i edges ago.
    // An input is "seen" S edges after sampling; the decision made on that
    // cycle lands in the output registers one edge later.
    bit [S+1:0] hs, hp, hc, hr;
    bit m_clk, m_tick, m_halted, m_step_mode;
    int m_guard_left, m_pulse, m_cnt;

    task automatic model_reset();
        hs = '0; hp = '0; hc = '0; hr = '0;
        m_clk = 0; m_tick = 0; m_halted = 0; m_step_mode = 0;
        m_guard_left = GC; m_pulse = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit srise, sfall, ptog, cedge, crise;
        hs = {hs[S:0], slowClk};
        hp = {hp[S:0], pressClk};
        hc = {hc[S:0], clockChooser};
        hr = {hr[S:0], clearHalt};
        srise = hs[S] && !hs[S+1];
        sfall = !hs[S] && hs[S+1];
        ptog  = hp[S] != hp[S+1];
        cedge = hc[S] != hc[S+1];
        crise = hr[S] && !hr[S+1];
        m_tick = 0;
        if (halt && !m_halted) begin
            m_halted = 1; m_guard_left = 0; m_clk = 0; m_pulse = 0;
        end else if (m_halted) begin
            m_clk = 0;
            if (crise && !halt) begin m_halted = 0; m_guard_left = GC; end
        end else if (m_guard_left > 0) begin
            m_clk = 0;
            m_guard_left--;
            if (m_guard_left == 0) m_step_mode = hc[S];
        end else if (cedge) begin
            m_clk = 0; m_pulse = 0; m_guard_left = GC;
        end else if (m_step_mode) begin
            if (m_pulse > 0) begin
                m_pulse--;
                if (m_pulse == 0) m_clk = 0;
            end else if (ptog) begin
                m_clk = 1; m_tick = 1; m_pulse = PL;
            end
        end else begin
            if (srise) begin m_clk = 1; m_tick = 1; end
            else if (sfall) m_clk = 0;
        end
        if (m_tick) m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // slowClk generator, advanced once per cycle
    bit slow_run = 0, slow_rand = 0;
    int slow_half = 60, slow_cnt = 0;
    bit prev_tick = 0, wrap_seen = 0;
    int prev_cnt = 0;

    task automatic cyc();
        @(posedge fastClk);
        if (reset) model_reset(); else model_step();
        #1;
        cyc_n++;
        check("cpuClk", cpuClk_o, m_clk);
        check("cpuTick", cpuTick_o, m_tick);
        check("halted", halted_o, m_halted);
        check("tickCount", tickCount_o, m_cnt);
        check("tick_gap", cpuTick_o & prev_tick, 0);
        prev_tick = cpuTick_o;
        if (prev_cnt == (1 << CW) - 1 && tickCount_o == 0) wrap_seen = 1;
        prev_cnt = tickCount_o;
        if (slow_run) begin
            slow_cnt++;
            if (slow_cnt >= slow_half) begin
                slowClk = ~slowClk;
                slow_cnt = 0;
                if (slow_rand) slow_half = $urandom_range(3, 40);
            end
        end
    endtask

    task automatic wait_tick(input string tag, input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            cyc();
            if (cpuTick_o) begin at = cyc_n; break; end
        end
        check(tag, at >= 0, 1);
    endtask

    initial begin
        int t, t_prev, n, hl, s;
        reset = 1; slowClk = 0; pressClk = 0; clockChooser = 0; halt = 0; clearHalt = 0;
        model_reset();
        repeat (3) cyc();
        check("rst_cpuClk", cpuClk_o, 0);
        check("rst_tickCount", tickCount_o, 0);
        reset = 0;

        // 1: RUN from a 120-cycle slowClk
        slow_half = 60; slow_cnt = 0; slow_run = 1;
        wait_tick("t1_first_tick", 200, t_prev);
        check("t1_first_after_guard", t_prev > GC, 1);
        for (int k = 0; k < 4; k++) begin
            wait_tick("t1_tick", 200, t);
            check("t1_period", t - t_prev, 120);
            t_prev = t;
        end
        check("t1_count5", tickCount_o, 5);

        // 2: single step, 3 toggles ~1000 cycles apart
        slow_run = 0;
        clockChooser = 1;
        repeat (40) cyc();
        for (int k = 0; k < 3; k++) begin
            pressClk = ~pressClk;
            t_prev = cyc_n;
            wait_tick("t2_tick", 10, t);
            check("t2_lag", t - t_prev, 3);
            hl = 1;
            repeat (6) begin cyc(); if (cpuClk_o) hl++; end
            check("t2_pulse_len", hl, PL);
            repeat (990) cyc();
        end

        // 3: halt while cpuClk=1, then resume
        clockChooser = 0;
        slow_half = 60; slow_cnt = 0; slow_run = 1;
        wait_tick("t3_run_tick", 300, t);
        halt = 1;
        cyc();
        halt = 0;
        check("t3_halt_clk", cpuClk_o, 0);
        check("t3_halted", halted_o, 1);
        n = 0;
        repeat (400) begin cyc(); n += cpuTick_o; end
        check("t3_no_ticks", n, 0);
        halt = 1; cyc();
        clearHalt = 1; repeat (6) cyc();
        halt = 0; repeat (10) cyc();
        check("t3_clr_blocked", halted_o, 1);
        clearHalt = 0; repeat (6) cyc();
        clearHalt = 1; repeat (6) cyc();
        clearHalt = 0;
        check("t3_cleared", halted_o, 0);
        wait_tick("t3_resume", 300, t);

        // 4: mode change coincident with a slowClk rise
        slow_run = 0; slowClk = 0;
        repeat (70) cyc();
        pressClk = ~pressClk;
        repeat (5) cyc();
        slowClk = 1; clockChooser = 1;
        n = 0;
        repeat (40) begin cyc(); n += cpuTick_o; end
        check("t4_no_tick", n, 0);
        pressClk = ~pressClk;
        wait_tick("t4_step_tick", 10, t);

        // 5: 20 ticks through the 4-bit wrap
        clockChooser = 0;
        repeat (30) cyc();
        s = m_cnt;
        wrap_seen = 0;
        slow_half = 10; slow_cnt = 0; slow_run = 1;
        repeat (20) wait_tick("t5_tick", 40, t);
        check("t5_wrap_count", tickCount_o, (s + 20) % 16);
        check("t5_wrap_seen", wrap_seen, 1);

        // 6: async reset in the middle of a step pulse
        slow_run = 0; clockChooser = 1;
        repeat (30) cyc();
        pressClk = ~pressClk;
        wait_tick("t6_tick", 10, t);
        #2;
        reset = 1;
        model_reset();
        #1;
        check("t6_rst_clk", cpuClk_o, 0);
        check("t6_rst_tick", cpuTick_o, 0);
        check("t6_rst_halted", halted_o, 0);
        check("t6_rst_count", tickCount_o, 0);
        repeat (3) cyc();
        reset = 0;
        repeat (22) cyc();
        pressClk = ~pressClk;
        wait_tick("t6_step_after_rst", 10, t);

        // randomized soak
        slow_rand = 1; slow_half = 20; slow_cnt = 0; slow_run = 1;
        repeat (3000) begin
            cyc();
            if (halt) halt = 0;
            else if ($urandom_range(0, 299) == 0) halt = 1;
            if ($urandom_range(0, 149) == 0) pressClk = ~pressClk;
            if ($urandom_range(0, 499) == 0) clockChooser = ~clockChooser;
            if ($urandom_range(0, 199) == 0) clearHalt = ~clearHalt;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
